sc_lifo_arbiter: RTL
====================

Name: sc_lifo_arbiter

Overview:
- Shares one sc_lifo instance between NUM_REQ requesters, each able to push and pop.
- Round-robin arbitration issues at most one LIFO operation (push or pop) per cycle.
- Keeps a shadow occupancy count and gates grants on it, so the LIFO never overflows or underflows.
- Returns pop data tagged with the requester id; sequences a safe LIFO clear.
- Sits between client blocks and the sc_lifo, and drives all sc_lifo inputs.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- DATA_WIDTH, 32, data word width; matches sc_lifo data_width.
- LIFO_DEPTH, 12, log2 of LIFO capacity; matches sc_lifo lifo_depth; capacity is 2^LIFO_DEPTH words.
- RD_LATENCY, 1, cycles from lifo_rd high to valid lifo_data_out (1..4).

Ports:
- clk, in, 1, clock; all logic on the rising edge.
- reset_n, in, 1, asynchronous active-low reset.
- push_valid, in, NUM_REQ, per-requester push request.
- push_data, in, NUM_REQ*DATA_WIDTH, push words; requester i uses slice [i*DATA_WIDTH +: DATA_WIDTH].
- push_ready, out, NUM_REQ, one-hot push grant; the push completes in this cycle.
- pop_valid, in, NUM_REQ, per-requester pop request.
- pop_ready, out, NUM_REQ, one-hot pop grant.
- rsp_valid, out, 1, pop data valid (one-cycle pulse).
- rsp_id, out, $clog2(NUM_REQ), requester that owns rsp_data.
- rsp_data, out, DATA_WIDTH, popped word.
- clear_req, in, 1, request to clear the LIFO (pulse or level).
- clear_busy, out, 1, high while the clear sequence is in progress.
- count, out, LIFO_DEPTH+1, shadow occupancy.
- lifo_wr, out, 1, drives sc_lifo wr.
- lifo_data_in, out, DATA_WIDTH, drives sc_lifo data_in.
- lifo_rd, out, 1, drives sc_lifo rd.
- lifo_clear, out, 1, drives sc_lifo clear (active high).
- lifo_data_out, in, DATA_WIDTH, from sc_lifo data_out.
- lifo_full, in, 1, from sc_lifo full.
- lifo_empty, in, 1, from sc_lifo empty.
- err, out, 1, sticky consistency error.

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-low on reset_n.
- Reset values: all outputs 0, count=0, FSM=RUN, rr_ptr=0, response pipeline empty, err=0. Reset asserted mid-operation drops in-flight responses; there is no recovery.
- Grants are combinational from the registered state and the current-cycle valids. push_ready and pop_ready are never both high; across both vectors at most one bit is high.
- Eligibility:
  - Push eligible when push_valid[i] && count < 2^LIFO_DEPTH.
  - Pop eligible when pop_valid[i] && count > 0.
  - Nothing is eligible unless FSM=RUN.
- Within one requester, an eligible pop wins over an eligible push.
- Round-robin: search from rr_ptr upward with wrap for the first requester with any eligible op. After a grant to requester g, rr_ptr <= (g+1) mod NUM_REQ. rr_ptr does not change when nothing is granted.
- Push grant to g, same cycle: lifo_wr=1 and lifo_data_in=push_data slice g. Next edge: count+1.
- Pop grant to g, same cycle: lifo_rd=1. Next edge: count-1. Push (g, valid) into an RD_LATENCY-deep id shift pipeline.
- Response: rsp_valid, rsp_id and rsp_data appear exactly RD_LATENCY cycles after lifo_rd. rsp_data = lifo_data_out in that cycle (combinational pass, no extra register).
- lifo_data_in holds its last value when lifo_wr=0.
- FSM:
  - RUN: normal operation. clear_req=1 -> DRAIN. Grants are still evaluated in the cycle clear_req rises.
  - DRAIN: no grants; clear_busy=1. Waits until the id pipeline holds no valid entries, then -> CLR.
  - CLR: lifo_clear=1 for exactly one cycle; count <= 0; clear_busy=1; -> RUN.
  - clear_req still high on return to RUN starts another clear.
- Consistency check: err is set when (count==0) != lifo_empty, or (count==2^LIFO_DEPTH) != lifo_full. The check is masked in the cycle after any lifo_wr, lifo_rd or lifo_clear, to allow for sc_lifo status update latency. err clears only on reset.
- Width rules: count is LIFO_DEPTH+1 bits and never wraps; the guards forbid increment at full and decrement at 0.

Decomposition:
- Package sc_lifo_arb_pkg: state enum (RUN, DRAIN, CLR); function rr_pick(req_vec, ptr) returning a one-hot grant.
- Sub-module sc_lifo_rsp_pipe: RD_LATENCY-stage valid+id shift register with an any_valid output.
- The arbiter, counter, FSM and checker live in the top module.

Test Plan:
- Single requester, NUM_REQ=4: push 0xA, 0xB, 0xC, then pop x3 -> rsp_data 0xC, 0xB, 0xA; rsp_id=0 each time; count 3->0; each rsp_valid 1 cycle after lifo_rd.
- All 4 requesters hold push_valid continuously from empty -> grants rotate 0,1,2,3,0,... with one lifo_wr per cycle and count increasing by 1 per cycle.
- Fill to 4096 -> push_ready stays 0 while push_valid stays high. Pop_valid on requester 2 -> pop granted, count=4095. Next cycle a push is granted again.
- Requester 1 with push_valid and pop_valid both high at count=5 -> pop_ready[1]=1 and push_ready=0; rr_ptr moves to 2.
- clear_req pulse with a pop in flight (RD_LATENCY=3) -> no grants for the next cycles; the outstanding rsp still delivered with the correct id; then lifo_clear pulses once; count=0; clear_busy low the cycle after.
- Assert reset_n=0 asynchronously mid-stream -> all outputs 0 immediately. With a model LIFO forcing lifo_empty=0 while count=0, err=1 after the mask cycle and stays high.

Source files
------------

// File: rtl/sc_lifo_arb_pkg.sv
// Shared types and the round-robin picker for the sc_lifo arbiter.
package sc_lifo_arb_pkg;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_DRAIN = 2'd1,
        ST_CLR   = 2'd2
    } arb_state_e;

    // Widest requester vector the picker handles.
    localparam int MAX_REQ = 8;

    // One-hot grant for the first set bit at or above ptr, wrapping at num_req.
    function automatic logic [MAX_REQ-1:0] rr_pick(
        input logic [MAX_REQ-1:0] req_vec,
        input logic [2:0]         ptr,
        input int                 num_req
    );
        logic [MAX_REQ-1:0] gnt;
        logic               found;
        int                 idx;
        gnt   = '0;
        found = 1'b0;
        for (int i = 0; i < MAX_REQ; i++) begin
            idx = int'(ptr) + i;
            if (idx >= num_req) idx = idx - num_req;
            if ((i < num_req) && !found && req_vec[idx[2:0]]) begin
                gnt[idx[2:0]] = 1'b1;
                found         = 1'b1;
            end
        end
        return gnt;
    endfunction

endpackage

// File: rtl/sc_lifo_rsp_pipe.sv
// Tracks which requester owns each outstanding LIFO read until its data returns.
module sc_lifo_rsp_pipe
    import sc_lifo_arb_pkg::*;
#(
    parameter int RD_LATENCY = 1,
    parameter int ID_W       = 2
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            in_valid,
    input  logic [ID_W-1:0] in_id,
    output logic            out_valid,
    output logic [ID_W-1:0] out_id,
    output logic            any_valid
);

    logic [RD_LATENCY-1:0] vld_q, vld_d;
    logic [ID_W-1:0]       id_q [RD_LATENCY];
    logic [ID_W-1:0]       id_d [RD_LATENCY];

    // Shift one stage per cycle; stage 0 takes the new read.
    always_comb begin
        vld_d[0] = in_valid;
        id_d[0]  = in_id;
        for (int i = 1; i < RD_LATENCY; i++) begin
            vld_d[i] = vld_q[i-1];
            id_d[i]  = id_q[i-1];
        end
    end

    // Stage registers; reset drops anything in flight.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            vld_q <= '0;
            for (int i = 0; i < RD_LATENCY; i++) id_q[i] <= '0;
        end else begin
            vld_q <= vld_d;
            for (int i = 0; i < RD_LATENCY; i++) id_q[i] <= id_d[i];
        end
    end

    assign out_valid = vld_q[RD_LATENCY-1];
    assign out_id    = id_q[RD_LATENCY-1];
    assign any_valid = |vld_q;

endmodule

// File: rtl/sc_lifo_arbiter.sv
// Round-robin front end sharing one sc_lifo among several push/pop clients.
//
//   state    | meaning
//   ---------+-----------------------------------------------------
//   ST_RUN   | normal arbitration, one LIFO op per cycle at most
//   ST_DRAIN | clear requested; no grants, wait for reads to return
//   ST_CLR   | one-cycle lifo_clear, shadow count forced to zero
module sc_lifo_arbiter
    import sc_lifo_arb_pkg::*;
#(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 32,
    parameter int LIFO_DEPTH = 12,
    parameter int RD_LATENCY = 1
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic [NUM_REQ-1:0]            push_valid,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] push_data,
    output logic [NUM_REQ-1:0]            push_ready,
    input  logic [NUM_REQ-1:0]            pop_valid,
    output logic [NUM_REQ-1:0]            pop_ready,
    output logic                          rsp_valid,
    output logic [$clog2(NUM_REQ)-1:0]    rsp_id,
    output logic [DATA_WIDTH-1:0]         rsp_data,
    input  logic                          clear_req,
    output logic                          clear_busy,
    output logic [LIFO_DEPTH:0]           count,
    output logic                          lifo_wr,
    output logic [DATA_WIDTH-1:0]         lifo_data_in,
    output logic                          lifo_rd,
    output logic                          lifo_clear,
    input  logic [DATA_WIDTH-1:0]         lifo_data_out,
    input  logic                          lifo_full,
    input  logic                          lifo_empty,
    output logic                          err
);

    localparam int                  ID_W = $clog2(NUM_REQ);
    localparam logic [LIFO_DEPTH:0] CAP  = {1'b1, {LIFO_DEPTH{1'b0}}};

    arb_state_e            state_q, state_d;
    logic [LIFO_DEPTH:0]   count_q, count_d;
    logic [ID_W-1:0]       rr_ptr_q, rr_ptr_d;
    logic [DATA_WIDTH-1:0] data_in_q, data_in_d;
    logic                  mask_q, mask_d;
    logic                  err_q, err_d;

    logic                  run_en;
    logic [NUM_REQ-1:0]    pop_elig, push_elig, gnt;
    logic [ID_W-1:0]       gnt_idx;
    logic                  any_gnt;
    logic [DATA_WIDTH-1:0] push_word [NUM_REQ];
    logic                  pipe_out_valid, pipe_any;
    logic [ID_W-1:0]       pipe_out_id;

    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_word
        assign push_word[gi] = push_data[gi*DATA_WIDTH +: DATA_WIDTH];
    end

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state_q <= ST_RUN;
        else          state_q <= state_d;
    end

    // Clear sequencing: drain outstanding reads before clearing the LIFO.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RUN:   if (clear_req) state_d = ST_DRAIN;
            ST_DRAIN: if (!pipe_any) state_d = ST_CLR;
            ST_CLR:   state_d = ST_RUN;
            default:  state_d = ST_RUN;
        endcase
    end

    // FSM outputs.
    always_comb begin
        run_en     = (state_q == ST_RUN);
        clear_busy = (state_q == ST_DRAIN) || (state_q == ST_CLR);
        lifo_clear = (state_q == ST_CLR);
    end

    // Eligibility gated by shadow count, then round-robin pick; pop beats push.
    // reset_n also gates eligibility so grants stay quiet while reset is held.
    always_comb begin
        pop_elig  = '0;
        push_elig = '0;
        if (run_en && reset_n) begin
            if (count_q != '0)  pop_elig  = pop_valid;
            if (count_q != CAP) push_elig = push_valid;
        end
        gnt        = NUM_REQ'(rr_pick(MAX_REQ'(pop_elig | push_elig), 3'(rr_ptr_q), NUM_REQ));
        pop_ready  = gnt & pop_elig;
        push_ready = gnt & push_elig & ~pop_elig;
        any_gnt    = |gnt;
        gnt_idx    = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (gnt[i]) gnt_idx = ID_W'(i);
        end
    end

    assign lifo_wr      = |push_ready;
    assign lifo_rd      = |pop_ready;
    assign lifo_data_in = lifo_wr ? push_word[gnt_idx] : data_in_q;

    // Next values for pointer, count, held write data and the status checker.
    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (any_gnt) rr_ptr_d = (gnt_idx == ID_W'(NUM_REQ-1)) ? '0 : gnt_idx + 1'b1;

        count_d = count_q;
        if (lifo_clear)   count_d = '0;
        else if (lifo_wr) count_d = count_q + 1'b1;
        else if (lifo_rd) count_d = count_q - 1'b1;

        data_in_d = lifo_data_in;

        // sc_lifo status may lag one cycle behind any operation.
        mask_d = lifo_wr | lifo_rd | lifo_clear;
        err_d  = err_q | (!mask_q && (((count_q == '0) != lifo_empty) ||
                                      ((count_q == CAP) != lifo_full)));
    end

    // Datapath registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count_q   <= '0;
            rr_ptr_q  <= '0;
            data_in_q <= '0;
            mask_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            count_q   <= count_d;
            rr_ptr_q  <= rr_ptr_d;
            data_in_q <= data_in_d;
            mask_q    <= mask_d;
            err_q     <= err_d;
        end
    end

    sc_lifo_rsp_pipe #(
        .RD_LATENCY (RD_LATENCY),
        .ID_W       (ID_W)
    ) u_rsp_pipe (
        .clk       (clk),
        .reset_n   (reset_n),
        .in_valid  (lifo_rd),
        .in_id     (gnt_idx),
        .out_valid (pipe_out_valid),
        .out_id    (pipe_out_id),
        .any_valid (pipe_any)
    );

    assign rsp_valid = pipe_out_valid;
    assign rsp_id    = pipe_out_id;
    assign rsp_data  = pipe_out_valid ? lifo_data_out : '0;
    assign count     = count_q;
    assign err       = err_q;

endmodule
